// File: rtl/mult_sequencer.sv
// -----------------------------------------------------------------------------
// mult_sequencer
//
// Control FSM for an add-shift signed multiplier datapath. The datapath has an
// X/A accumulator, a B multiplier register, a 9-bit adder/subtracter and an
// arithmetic shifter. This block turns the Run and Load_Clear requests into
// one-cycle datapath strobes. Each multiply performs WIDTH iterations. Every
// iteration takes one OP cycle and one SH cycle, so latency is fixed.
//
// Ports
//   Clk         system clock, rising edge
//   Reset       asynchronous, active-low reset
//   Run         start a multiply (synchronized, debounced)
//   Load_Clear  clear X/A and load B from the switches (synchronized)
//   M           current B[0] from the datapath
//   Clr_Ld      strobe: X/A <= 0, B <= SW
//   Clr_XA      strobe: X/A <= 0 at the start of a multiply
//   Add         strobe: X/A <= X/A + SW (9-bit, sign-extended)
//   Sub         strobe: X/A <= X/A - SW (sign-bit correction, last iteration)
//   Shift       strobe: arithmetic right shift of {X,A,B}
//   Busy        high from START through the last SH state
//   Done        high while in DONE
//   Iter        current iteration index, 0..WIDTH-1
// -----------------------------------------------------------------------------
module mult_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Load_Clear,
    input  logic             M,
    output logic             Clr_Ld,
    output logic             Clr_XA,
    output logic             Add,
    output logic             Sub,
    output logic             Shift,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Iter
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR_LD = 3'd1,
        S_START  = 3'd2,
        S_OP     = 3'd3,
        S_SH     = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] iter_q;
    logic [CNT_W-1:0] iter_d;
    logic             last_iter;

    // The compare uses the current index before any increment. The counter
    // therefore stops at WIDTH-1 and never wraps.
    assign last_iter = (iter_q == LAST_ITER);
    assign Iter      = iter_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // The next state and all outputs come from the registered state. The only
    // Mealy term is M, which gates Add/Sub in OP. A reset clears state_q
    // asynchronously, so every strobe drops without waiting for a clock edge.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        Clr_Ld  = 1'b0;
        Clr_XA  = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        Shift   = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A load request wins over a run request.
                if (Load_Clear) begin
                    state_d = S_CLR_LD;
                end else if (Run) begin
                    state_d = S_START;
                end
            end

            S_CLR_LD: begin
                Clr_Ld  = 1'b1;
                state_d = S_IDLE;
            end

            S_START: begin
                Clr_XA  = 1'b1;
                Busy    = 1'b1;
                iter_d  = '0;
                state_d = S_OP;
            end

            S_OP: begin
                Busy = 1'b1;
                // B[7] carries negative weight, so the last partial product
                // is subtracted. When M=0 the cycle is still spent, which
                // keeps the latency fixed.
                if (M) begin
                    if (last_iter) begin
                        Sub = 1'b1;
                    end else begin
                        Add = 1'b1;
                    end
                end
                state_d = S_SH;
            end

            S_SH: begin
                Shift = 1'b1;
                Busy  = 1'b1;
                if (last_iter) begin
                    state_d = S_DONE;
                end else begin
                    iter_d  = iter_q + CNT_W'(1);
                    state_d = S_OP;
                end
            end

            S_DONE: begin
                Done = 1'b1;
                // Stay here while Run is held, so each press gives one multiply.
                if (!Run) begin
                    state_d = Load_Clear ? S_CLR_LD : S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_sequencer
//
// Bench for mult_sequencer, with WIDTH=8. A small datapath model, made of
// X/A/B registers and SW, reacts to the strobes and feeds M back. Stimulus
// tasks push the expected strobe events into a queue, each with the cycle it
// should appear in. A negedge monitor pops an entry whenever the DUT shows a
// strobe or a rising Done, and compares the two.
// Cycle numbering: base is edge_n when Run/Load_Clear is driven. Cycle c of an
// operation is the one where edge_n == base + c.
// -----------------------------------------------------------------------------
module tb_mult_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic       Load_Clear;
    logic       M;
    logic       Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done;
    logic [2:0] Iter;

    mult_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .Load_Clear (Load_Clear),
        .M          (M),
        .Clr_Ld     (Clr_Ld),
        .Clr_XA     (Clr_XA),
        .Add        (Add),
        .Sub        (Sub),
        .Shift      (Shift),
        .Busy       (Busy),
        .Done       (Done),
        .Iter       (Iter)
    );

    always #5 Clk = ~Clk;

    int edge_n = 0;
    always @(posedge Clk) edge_n <= edge_n + 1;

    // Datapath model; it has no reset, like the real datapath.
    logic       x_m = 1'b0;
    logic [7:0] a_m = 8'h00;
    logic [7:0] b_m = 8'h00;
    logic [7:0] sw  = 8'h00;
    assign M = b_m[0];

    always @(posedge Clk) begin
        if (Clr_Ld) begin
            x_m <= 1'b0; a_m <= 8'h00; b_m <= sw;
        end else if (Clr_XA) begin
            x_m <= 1'b0; a_m <= 8'h00;
        end else if (Add) begin
            {x_m, a_m} <= {a_m[7], a_m} + {sw[7], sw};
        end else if (Sub) begin
            {x_m, a_m} <= {a_m[7], a_m} - {sw[7], sw};
        end else if (Shift) begin
            a_m <= {x_m, a_m[7:1]};
            b_m <= {a_m[0], b_m[7:1]};
        end
    end

    // Strobe vector bit order: Clr_Ld, Clr_XA, Add, Sub, Shift.
    localparam logic [4:0] ST_CLRLD = 5'b10000;
    localparam logic [4:0] ST_CLRXA = 5'b01000;
    localparam logic [4:0] ST_ADD   = 5'b00100;
    localparam logic [4:0] ST_SUB   = 5'b00010;
    localparam logic [4:0] ST_SHIFT = 5'b00001;

    typedef struct {
        int         cyc;
        logic [4:0] strb;
        logic       done;
        logic       busy;
        logic       chk_iter;
        logic [2:0] iter;
    } evt_t;

    evt_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    endtask

    task automatic push(input int cyc, input logic [4:0] strb, input logic done,
                        input logic busy, input logic ci, input logic [2:0] it);
        evt_t e;
        e.cyc = cyc; e.strb = strb; e.done = done; e.busy = busy; e.chk_iter = ci; e.iter = it;
        exp_q.push_back(e);
    endtask

    // Expected events for one full multiply with multiplier value b.
    task automatic push_mult(input int base, input logic [7:0] b);
        push(base + 1, ST_CLRXA, 1'b0, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) push(base + 2 + 2*i, (i < 7) ? ST_ADD : ST_SUB, 1'b0, 1'b1, 1'b1, 3'(i));
            push(base + 3 + 2*i, ST_SHIFT, 1'b0, 1'b1, 1'b1, 3'(i));
        end
        push(base + 18, 5'b00000, 1'b1, 1'b0, 1'b1, 3'd7);
    endtask

    // Monitor: pop and compare whenever a strobe or a rising Done is seen.
    logic       done_prev = 1'b0;
    logic [4:0] mon_s;
    logic       mon_dr;
    evt_t       mon_e;
    logic [2:0] mon_ia, mon_ie;
    always @(negedge Clk) begin
        mon_s     = {Clr_Ld, Clr_XA, Add, Sub, Shift};
        mon_dr    = Done & ~done_prev;
        done_prev = Done;
        if (mon_s != 5'b0 || mon_dr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1'b0, {edge_n[15:0], 11'b0, mon_s}, 32'h0);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ia = mon_e.chk_iter ? Iter : 3'd0;
                mon_ie = mon_e.chk_iter ? mon_e.iter : 3'd0;
                chk("evt{cyc,strb,done,busy,iter}",
                    (edge_n == mon_e.cyc) && (mon_s == mon_e.strb) && (mon_dr == mon_e.done)
                        && (Busy == mon_e.busy) && (mon_ia == mon_ie),
                    {6'b0, edge_n[15:0], mon_s, mon_dr, Busy, mon_ia},
                    {6'b0, mon_e.cyc[15:0], mon_e.strb, mon_e.done, mon_e.busy, mon_ie});
            end
        end
    end

    task automatic load_b(input logic [7:0] v);
        @(negedge Clk);
        sw = v;
        Load_Clear = 1'b1;
        push(edge_n + 1, ST_CLRLD, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge Clk);
        Load_Clear = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic run_mult(input string name, input logic [7:0] bval, input logic [7:0] swval,
                            input logic [15:0] prod, input bit interfere);
        int base;
        int k;
        load_b(bval);
        sw = swval;
        @(negedge Clk);
        Run  = 1'b1;
        base = edge_n;
        push_mult(base, bval);
        if (interfere) begin
            // Run and Load_Clear activity while Busy must not disturb anything.
            repeat (4) @(negedge Clk);
            Run = 1'b0;
            repeat (2) @(negedge Clk);
            Run = 1'b1;
            repeat (2) @(negedge Clk);
            Run = 1'b0;
            Load_Clear = 1'b1;
            @(negedge Clk);
            Load_Clear = 1'b0;
        end
        k = 0;
        while (!Done && k < 40) begin
            @(negedge Clk);
            k++;
        end
        chk({name, "_done_cycle"}, Done && (edge_n == base + 18), edge_n - base, 32'd18);
        chk({name, "_product"}, {a_m, b_m} == prod, {a_m, b_m}, prod);
        if (!interfere) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge Clk);
                chk({name, "_done_held"}, Done && !Busy && Iter == 3'd7, {Done, Busy, Iter}, {2'b10, 3'd7});
            end
            Run = 1'b0;
        end
        @(negedge Clk);
        chk({name, "_idle_after"}, !Done && !Busy, {Done, Busy}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        Reset = 1'b1; Run = 1'b1; Load_Clear = 1'b1;
        #1 Reset = 1'b0;
        // An asynchronous reset must take effect before any clock edge.
        #1 chk("reset_async", {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done, Iter} == 10'b0,
                {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done, Iter}, 32'h0);
        repeat (3) @(negedge Clk);
        chk("reset_held", {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done, Iter} == 10'b0,
            {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done, Iter}, 32'h0);
        Run = 1'b0; Load_Clear = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("idle_quiet", {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done} == 7'b0,
                {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done}, 32'h0);
        end

        // A single Load_Clear pulse gives exactly one Clr_Ld cycle.
        load_b(8'h3C);

        // Load_Clear and Run together: CLR_LD is taken, not START.
        @(negedge Clk);
        sw = 8'h11; Load_Clear = 1'b1; Run = 1'b1;
        push(edge_n + 1, ST_CLRLD, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge Clk);
        Load_Clear = 1'b0; Run = 1'b0;
        @(negedge Clk);
        chk("priority_no_start", !Busy && !Clr_XA, {Busy, Clr_XA}, 2'b00);
        repeat (2) @(negedge Clk);

        run_mult("b07", 8'h07, 8'h07, 16'h0031, 1'b0);
        run_mult("bff", 8'hFF, 8'h02, 16'hFFFE, 1'b0);
        run_mult("busy_ignore", 8'h05, 8'h03, 16'h000F, 1'b1);

        // Reset in OP3 (cycle 8) of a multiply with B=FF.
        load_b(8'hFF);
        sw = 8'h02;
        @(negedge Clk);
        Run  = 1'b1;
        base = edge_n;
        push(base + 1, ST_CLRXA, 1'b0, 1'b1, 1'b0, 3'd0);
        for (int j = 0; j < 4; j++) begin
            push(base + 2 + 2*j, ST_ADD, 1'b0, 1'b1, 1'b1, 3'(j));
            if (j < 3) push(base + 3 + 2*j, ST_SHIFT, 1'b0, 1'b1, 1'b1, 3'(j));
        end
        repeat (8) @(negedge Clk);
        #2;
        Reset = 1'b0;
        Run   = 1'b0;
        #1 chk("reset_mid_op", {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done, Iter} == 10'b0,
                {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done, Iter}, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        run_mult("after_reset", 8'hFF, 8'h02, 16'hFFFE, 1'b0);

        repeat (3) @(negedge Clk);
        chk("queue_empty", exp_q.size() == 0, exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
